sipo_deser: RTL and testbench
=============================

# sipo_deser

Parametrised serial-in/parallel-out deserialiser. It is the successor to the fixed 4-bit SIPO shift register. It collects `WIDTH` qualified serial bits into a word in either bit order and presents the word on a valid/ready output holding register. Overrun is detected, and an optional parity check is available. It sits between a serial bit source (line receiver or bit-bang interface) and word-oriented downstream logic.

## Interface
- `WIDTH`, 8: word width in bits; minimum 2.
- `MSB_FIRST`, 1: 1 = first received bit lands in `po[WIDTH-1]`; 0 = first received bit lands in `po[0]`.
- `clk`  input  1  clock; all state changes on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `sin`  input  1  serial data bit, sampled only when `sin_valid`=1.
- `sin_valid`  input  1  qualifies `sin` for this cycle.
- `flush`  input  1  abandons the partially assembled word.
- `po`  output  WIDTH  parallel word.
- `po_valid`  output  1  `po` holds an unconsumed word.
- `po_ready`  input  1  consumer accepts `po` on an edge where `po_valid`=1.
- `bit_cnt`  output  $clog2(WIDTH+2)  number of bits of the current frame received so far.
- `overrun`  output  1  one-cycle pulse: a completed word was dropped.
- `par_err`  output  1  parity error for the word in `po`; valid while `po_valid`=1.

## Operation
- Frame length is FL = `WIDTH`, or `WIDTH`+1 when the parity feature is compiled in.
- Internal state:
  - `sr[WIDTH-1:0]` is the assembly register.
  - `bit_cnt` runs 0..FL-1.
- Data bit accepted (`sin_valid`=1 and `bit_cnt` < `WIDTH`):
  - `MSB_FIRST`=1: `sr` <= {`sr[WIDTH-2:0]`, `sin`}.
  - `MSB_FIRST`=0: `sr` <= {`sin`, `sr[WIDTH-1:1]`}.
  - `bit_cnt` increments.
- Frame completion: the edge on which `sin_valid`=1 and `bit_cnt`=FL-1.
  - `bit_cnt` <= 0.
  - The assembled word (`sr` including the bit shifted in on this edge) is the candidate.
- Completion with output slot free (`po_valid`=0, or `po_ready`=1 on the same edge):
  - `po` <= candidate, `po_valid` <= 1, `par_err` updated.
- Completion with output slot occupied (`po_valid`=1 and `po_ready`=0):
  - Candidate is discarded.
  - `po` and `par_err` are unchanged.
  - `overrun` = 1 for exactly one cycle.
- Consumer acceptance without a completion: `po_valid`=1 and `po_ready`=1 clears `po_valid`.
- `po_ready` with `po_valid`=0 has no effect.
- `sin_valid`=0: `sr` and `bit_cnt` hold; gaps of any length are allowed between bits.
- `flush`=1:
  - `sr` <= 0 and `bit_cnt` <= 0.
  - `flush` has priority over a simultaneous `sin_valid`; that bit is dropped.
  - `po`, `po_valid` and `par_err` are not affected; output handshake continues normally.
- `rst`=1, regardless of state or mid-frame position:
  - `sr`=0, `bit_cnt`=0, `po`=0, `po_valid`=0, `overrun`=0, `par_err`=0.
  - `rst` overrides all other inputs.

## Timing
- Latency: `po`/`po_valid` are visible immediately after the edge that samples the final frame bit. A frame therefore needs FL qualified edges.
- Back-to-back frames at one bit per cycle are lossless if the consumer holds `po_ready`=1.
- `overrun` is registered and asserts in the cycle following the dropping edge.
- Every output is a register output; there are no combinational paths from inputs to outputs.

## Configuration
- Macro `SIPO_DESER_PARITY_EN`.
- Defined:
  - FL = `WIDTH`+1; the bit after the data bits is an even-parity bit and is not shifted into `sr`.
  - At completion, `par_err` <= XOR of the `WIDTH` data bits and the parity bit.
- Undefined:
  - FL = `WIDTH`; no parity hardware.
  - `par_err` is constant 0.

## Test plan
- `WIDTH`=4, `MSB_FIRST`=1, `po_ready`=1; serial 1,0,1,1 on 4 consecutive edges -> `po`=4'b1011 and `po_valid`=1 after the 4th edge; `bit_cnt` reads 1,2,3,0.
- Same stream with `MSB_FIRST`=0 and 2-cycle `sin_valid` gaps between bits -> `po`=4'b1101 after the 4th qualified edge; nothing changes during the gaps.
- `WIDTH`=8, `po_ready`=0; send 8'hA5 then 8'h3C -> `po` stays 8'hA5 and `overrun` pulses once. Then raise `po_ready` -> `po_valid` drops, and a following 8'h3C is delivered.
- `WIDTH`=8; 5 bits, then `flush`, then 8'hF0 -> `po`=8'hF0. Separately, asserting `rst` after 3 bits -> all outputs 0, and the next 8 bits form a clean word.
- `SIPO_DESER_PARITY_EN`, `WIDTH`=8; 8'h07 with parity bit 1 -> `par_err`=0. 8'h07 with parity bit 0 -> `par_err`=1, `po`=8'h07, and `po_valid` rises after the 9th bit.
- Continuous 1-bit/cycle stream of 4 words with `po_ready`=1 -> 4 `po_valid` words in order, `overrun` never asserted.

Source files
------------

// File: rtl/sipo_deser.sv
// Parametrised serial-in/parallel-out deserialiser with a valid/ready output register.
// Optional even-parity check: define SIPO_DESER_PARITY_EN to add a parity bit to each frame.
module sipo_deser #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        sin,
  input  logic                        sin_valid,
  input  logic                        flush,
  output logic [WIDTH-1:0]            po,
  output logic                        po_valid,
  input  logic                        po_ready,
  output logic [$clog2(WIDTH+2)-1:0]  bit_cnt,
  output logic                        overrun,
  output logic                        par_err
);

  localparam int CW = $clog2(WIDTH + 2);
`ifdef SIPO_DESER_PARITY_EN
  localparam int FL = WIDTH + 1;
`else
  localparam int FL = WIDTH;
`endif
  localparam logic [CW-1:0] LAST_CNT = CW'(FL - 1);
  localparam logic [CW-1:0] DATA_CNT = CW'(WIDTH);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] po_q, po_d;
  logic             po_valid_q, po_valid_d;
  logic             overrun_q, overrun_d;
  logic             accept, data_bit, complete, slot_free;
  logic [WIDTH-1:0] shifted, candidate;

  always_comb begin
    accept    = sin_valid && !flush;
    data_bit  = accept && (cnt_q < DATA_CNT);
    complete  = accept && (cnt_q == LAST_CNT);
    slot_free = !po_valid_q || po_ready;
    if (MSB_FIRST) shifted = {sr_q[WIDTH-2:0], sin};
    else           shifted = {sin, sr_q[WIDTH-1:1]};
`ifdef SIPO_DESER_PARITY_EN
    // The completing bit is the parity bit, so the word is already fully in sr.
    candidate = sr_q;
`else
    candidate = shifted;
`endif
  end

  // Assembly register and frame counter; flush wins over a same-cycle bit.
  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (flush) begin
      sr_d  = '0;
      cnt_d = '0;
    end else if (accept) begin
      if (data_bit) sr_d = shifted;
      cnt_d = complete ? '0 : cnt_q + CW'(1);
    end
  end

  // Output handshake: a word is transferred on any edge where po_valid=1 and
  // po_ready=1. A completion may refill the slot on that same edge; a completion
  // while the slot is held (po_valid=1, po_ready=0) is dropped and flagged.
  always_comb begin
    po_d       = po_q;
    po_valid_d = po_valid_q;
    overrun_d  = 1'b0;
    if (po_valid_q && po_ready) po_valid_d = 1'b0;
    if (complete) begin
      if (slot_free) begin
        po_d       = candidate;
        po_valid_d = 1'b1;
      end else begin
        overrun_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q       <= '0;
      cnt_q      <= '0;
      po_q       <= '0;
      po_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      po_q       <= po_d;
      po_valid_q <= po_valid_d;
      overrun_q  <= overrun_d;
    end
  end

`ifdef SIPO_DESER_PARITY_EN
  logic par_err_q, par_err_d;

  always_comb begin
    par_err_d = par_err_q;
    if (complete && slot_free) par_err_d = (^sr_q) ^ sin;
  end

  always_ff @(posedge clk) begin
    if (rst) par_err_q <= 1'b0;
    else     par_err_q <= par_err_d;
  end

  assign par_err = par_err_q;
`else
  assign par_err = 1'b0;
`endif

  assign po       = po_q;
  assign po_valid = po_valid_q;
  assign bit_cnt  = cnt_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_sipo_deser.sv
// Directed bench for sipo_deser: two 4-bit instances (both bit orders) and one 8-bit instance.
// Honours SIPO_DESER_PARITY_EN by appending parity bits and running the parity cases.
module tb_sipo_deser;

`ifdef SIPO_DESER_PARITY_EN
  localparam int FL4 = 5;
  localparam int FL8 = 9;
`else
  localparam int FL4 = 4;
  localparam int FL8 = 8;
`endif

  logic clk = 1'b0;
  logic rst;

  // 4-bit pair shares its inputs
  logic       sin_a, sv_a, flush_a, rdy_a;
  logic [3:0] po_4m, po_4l;
  logic       pv_4m, pv_4l, ovr_4m, ovr_4l, perr_4m, perr_4l;
  logic [2:0] cnt_4m, cnt_4l;

  logic       sin8, sv8, flush8, rdy8;
  logic [7:0] po8;
  logic       pv8, ovr8, perr8;
  logic [3:0] cnt8;

  int n_tests = 0;
  int n_fail  = 0;
  logic       mon_en = 1'b0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] word;
    logic       rdy;
    logic       pre_ack;
    logic [7:0] exp_po;
    logic       exp_pv;
    logic       exp_ovr;
  } vec_t;
  vec_t tbl[6];

  sipo_deser #(.WIDTH(4), .MSB_FIRST(1'b1)) u4m (
    .clk(clk), .rst(rst), .sin(sin_a), .sin_valid(sv_a), .flush(flush_a),
    .po(po_4m), .po_valid(pv_4m), .po_ready(rdy_a), .bit_cnt(cnt_4m),
    .overrun(ovr_4m), .par_err(perr_4m));

  sipo_deser #(.WIDTH(4), .MSB_FIRST(1'b0)) u4l (
    .clk(clk), .rst(rst), .sin(sin_a), .sin_valid(sv_a), .flush(flush_a),
    .po(po_4l), .po_valid(pv_4l), .po_ready(rdy_a), .bit_cnt(cnt_4l),
    .overrun(ovr_4l), .par_err(perr_4l));

  sipo_deser #(.WIDTH(8), .MSB_FIRST(1'b1)) u8 (
    .clk(clk), .rst(rst), .sin(sin8), .sin_valid(sv8), .flush(flush8),
    .po(po8), .po_valid(pv8), .po_ready(rdy8), .bit_cnt(cnt8),
    .overrun(ovr8), .par_err(perr8));

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish (act=running exp=done)");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // drivers: drive on negedge, sample 1 time unit after the posedge
  task automatic bit_a(input logic b, input logic v);
    @(negedge clk); sin_a = b; sv_a = v;
    @(posedge clk); #1; sv_a = 1'b0;
  endtask

  task automatic bit8(input logic b, input logic v);
    @(negedge clk); sin8 = b; sv8 = v;
    @(posedge clk); #1; sv8 = 1'b0;
  endtask

  task automatic idle8(input int n);
    for (int i = 0; i < n; i++) bit8(1'b0, 1'b0);
  endtask

  task automatic frame8(input logic [7:0] w, input logic par);
    for (int k = 0; k < 8; k++) begin
      bit8(w[7-k], 1'b1);
      chk("cnt8", 32'(cnt8), 32'((k + 1) % FL8));
    end
`ifdef SIPO_DESER_PARITY_EN
    bit8(par, 1'b1);
    chk("cnt8_par", 32'(cnt8), 32'd0);
`else
    if (par === 1'bx) $display("unused parity argument");
`endif
  endtask

  // scoreboard monitor for the streaming test
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      chk("stream_ovr", 32'(ovr8), 32'd0);
      if (pv8) begin
        if (exp_q.size() == 0) chk("stream_extra_word", 32'(po8), 32'hFFFF);
        else chk("stream_po", 32'(po8), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    logic [3:0] s4;
    logic [7:0] words [4];

    tbl[0] = '{8'hA5, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0};
    tbl[1] = '{8'h3C, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b1};
    tbl[2] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0};
    tbl[3] = '{8'h5A, 1'b1, 1'b0, 8'h5A, 1'b1, 1'b0};
    tbl[4] = '{8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0};
    tbl[5] = '{8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};

    rst = 1'b1; sin_a = 0; sv_a = 0; flush_a = 0; rdy_a = 1;
    sin8 = 0; sv8 = 0; flush8 = 0; rdy8 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_po", 32'(po8), 32'd0);
    chk("rst_pv", 32'(pv8), 32'd0);
    chk("rst_cnt", 32'(cnt8), 32'd0);
    chk("rst_ovr", 32'(ovr8), 32'd0);
    chk("rst_perr", 32'(perr8), 32'd0);
    @(negedge clk); rst = 1'b0;

    // 4-bit: 1,0,1,1 on consecutive edges
    s4 = 4'b1011;
    for (int k = 0; k < 4; k++) begin
      bit_a(s4[3-k], 1'b1);
      chk("cnt4_consec", 32'(cnt_4m), 32'((k + 1) % FL4));
    end
`ifdef SIPO_DESER_PARITY_EN
    bit_a(^s4, 1'b1);
    chk("cnt4_par", 32'(cnt_4m), 32'd0);
    chk("perr4", 32'(perr_4m), 32'd0);
`endif
    chk("po4_msb", 32'(po_4m), 32'b1011);
    chk("pv4_msb", 32'(pv_4m), 32'd1);
    chk("po4_lsb", 32'(po_4l), 32'b1101);

    // same stream with 2-cycle gaps between qualified bits
    for (int k = 0; k < FL4; k++) begin
      if (k < 4) bit_a(s4[3-k], 1'b1);
      else       bit_a(^s4, 1'b1);
      for (int g = 0; g < 2; g++) begin
        bit_a(1'b1, 1'b0);
        chk("cnt4_gap", 32'(cnt_4l), 32'((k + 1) % FL4));
      end
    end
    chk("po4_lsb_gap", 32'(po_4l), 32'b1101);
    chk("pv4_lsb_gap", 32'(pv_4l), 32'd0);

    // 8-bit table: overrun, acceptance, delivery
    for (int i = 0; i < 6; i++) begin
      if (tbl[i].pre_ack) begin
        rdy8 = 1'b1;
        idle8(1);
        chk("ack_pv", 32'(pv8), 32'd0);
        chk("ack_ovr", 32'(ovr8), 32'd0);
      end
      rdy8 = tbl[i].rdy;
      frame8(tbl[i].word, ^tbl[i].word);
      chk("tbl_po", 32'(po8), 32'(tbl[i].exp_po));
      chk("tbl_pv", 32'(pv8), 32'(tbl[i].exp_pv));
      chk("tbl_ovr", 32'(ovr8), 32'(tbl[i].exp_ovr));
      chk("tbl_perr", 32'(perr8), 32'd0);
      if (tbl[i].exp_ovr) begin
        idle8(1);
        chk("ovr_one_cycle", 32'(ovr8), 32'd0);
        chk("ovr_po_hold", 32'(po8), 32'hA5);
      end
    end

    // flush mid-frame, with a simultaneous bit that must be dropped
    rdy8 = 1'b1;
    for (int k = 0; k < 5; k++) bit8(1'b1, 1'b1);
    chk("pre_flush_cnt", 32'(cnt8), 32'd5);
    @(negedge clk); flush8 = 1'b1; sv8 = 1'b1; sin8 = 1'b1;
    @(posedge clk); #1; flush8 = 1'b0; sv8 = 1'b0;
    chk("flush_cnt", 32'(cnt8), 32'd0);
    frame8(8'hF0, ^8'hF0);
    chk("flush_po", 32'(po8), 32'hF0);
    chk("flush_pv", 32'(pv8), 32'd1);

    // reset after 3 bits, then a clean word
    for (int k = 0; k < 3; k++) bit8(1'b1, 1'b1);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_po", 32'(po8), 32'd0);
    chk("mid_rst_pv", 32'(pv8), 32'd0);
    chk("mid_rst_cnt", 32'(cnt8), 32'd0);
    chk("mid_rst_ovr", 32'(ovr8), 32'd0);
    @(negedge clk); rst = 1'b0;
    frame8(8'h96, ^8'h96);
    chk("post_rst_po", 32'(po8), 32'h96);
    chk("post_rst_pv", 32'(pv8), 32'd1);

`ifdef SIPO_DESER_PARITY_EN
    idle8(1);
    frame8(8'h07, 1'b1);
    chk("par_ok_po", 32'(po8), 32'h07);
    chk("par_ok_err", 32'(perr8), 32'd0);
    idle8(1);
    for (int k = 0; k < 8; k++) bit8(8'h07 >> (7 - k), 1'b1);
    chk("par_pv_before_9th", 32'(pv8), 32'd0);
    bit8(1'b0, 1'b1);
    chk("par_bad_pv", 32'(pv8), 32'd1);
    chk("par_bad_po", 32'(po8), 32'h07);
    chk("par_bad_err", 32'(perr8), 32'd1);
`endif

    // back-to-back stream, consumer always ready
    idle8(1);
    words[0] = 8'h11; words[1] = 8'hC3; words[2] = 8'h7E; words[3] = 8'h42;
    for (int w = 0; w < 4; w++) exp_q.push_back(words[w]);
    mon_en = 1'b1;
    for (int w = 0; w < 4; w++) frame8(words[w], ^words[w]);
    idle8(2);
    mon_en = 1'b0;
    chk("stream_all_delivered", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
